// File: rtl/instruction_decoder_pkg.sv
// Shared encodings for the 8-bit core: opcode prefixes, register codes and the
// NOPD8 stall length used by both the decoder and the program sequencer.
package instruction_decoder_pkg;

    localparam logic       LOAD_PFX = 1'b0;
    localparam logic [1:0] MOVE_PFX = 2'b10;
    localparam logic [2:0] ALU_PFX  = 3'b110;
    localparam logic [3:0] JMP_PFX  = 4'hE;
    localparam logic [3:0] JNZ_PFX  = 4'hF;

    localparam logic [7:0] NOP_CODE_DEFAULT = 8'hBF;

    // Final phase of the 3-cycle NOPD8; the sequencer's counter uses the same value.
    localparam logic [1:0] STALL_LAST = 2'd2;

    typedef enum logic [2:0] {
        REG_0 = 3'd0,
        REG_1 = 3'd1,
        REG_2 = 3'd2,
        REG_3 = 3'd3,
        REG_4 = 3'd4,
        REG_5 = 3'd5,
        REG_6 = 3'd6,
        REG_7 = 3'd7
    } reg_code_e;

    function automatic logic [7:0] reg_onehot(input reg_code_e code);
        return 8'b0000_0001 << code;
    endfunction

endpackage

// File: rtl/instruction_decoder_stall.sv
// NOPD8 stall-phase counter; steps 0,1,2 while NOPD8 is decoded and holds pc
// for the first two phases. Intended for reuse by the program sequencer.
module nop_stall_counter
    import instruction_decoder_pkg::*;
(
    input  logic       clk,
    input  logic       sync_reset,
    input  logic       nopd8,
    output logic [1:0] cnt,
    output logic       stall
);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            cnt <= 2'd0;
        end else if (nopd8 && cnt != STALL_LAST) begin
            cnt <= cnt + 2'd1;
        end else if (cnt == STALL_LAST) begin
            cnt <= 2'd0;
        end
    end

    assign stall = nopd8 && (cnt < STALL_LAST);

endmodule

// File: rtl/instruction_decoder.sv
// Instruction decoder: combinational control decode of ir, zero flag, NOPD8
// stall tracking and a retired-instruction counter aligned with the sequencer.
module instruction_decoder
    import instruction_decoder_pkg::*;
#(
    parameter logic [7:0]  NOP_CODE = NOP_CODE_DEFAULT,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             sync_reset,
    input  logic [7:0]       ir,
    input  logic             alu_zero,
    output logic             jmp,
    output logic             jmp_nz,
    output logic [3:0]       jmp_addr,
    output logic             dont_jmp,
    output logic             NOPD8,
    output logic [7:0]       reg_en,
    output logic [2:0]       src_sel,
    output logic             imm_sel,
    output logic             alu_en,
    output logic             alu_y_sel,
    output logic [3:0]       alu_fn,
    output logic             stall,
    output logic [CNT_W-1:0] instr_count
);

    logic       z;
    logic [1:0] cnt;

    // NOTE: every output gets a default before the decode so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    always_comb begin
        jmp       = 1'b0;
        jmp_nz    = 1'b0;
        jmp_addr  = 4'h0;
        NOPD8     = 1'b0;
        reg_en    = 8'h00;
        src_sel   = 3'd0;
        imm_sel   = 1'b0;
        alu_en    = 1'b0;
        alu_y_sel = 1'b0;
        alu_fn    = 4'h0;
        if (!sync_reset) begin
            // NOP_CODE sits inside the move encoding space, so it is tested first.
            if (ir == NOP_CODE) begin
                NOPD8 = 1'b1;
            end else if (ir[7] == LOAD_PFX) begin
                reg_en  = reg_onehot(reg_code_e'(ir[6:4]));
                imm_sel = 1'b1;
            end else if (ir[7:6] == MOVE_PFX) begin
                reg_en  = reg_onehot(reg_code_e'(ir[5:3]));
                src_sel = ir[2:0];
            end else if (ir[7:5] == ALU_PFX) begin
                alu_en    = 1'b1;
                alu_y_sel = ir[4];
                alu_fn    = ir[3:0];
            end else if (ir[7:4] == JMP_PFX) begin
                jmp      = 1'b1;
                jmp_addr = ir[3:0];
            end else if (ir[7:4] == JNZ_PFX) begin
                jmp_nz   = 1'b1;
                jmp_addr = ir[3:0];
            end
        end
    end

    nop_stall_counter u_stall (
        .clk        (clk),
        .sync_reset (sync_reset),
        .nopd8      (NOPD8),
        .cnt        (cnt),
        .stall      (stall)
    );

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            z <= 1'b0;
        end else if (alu_en) begin
            z <= alu_zero;
        end
    end

    // Gated so the flag reads 0 in the reset cycle even before the first reset edge.
    assign dont_jmp = z && !sync_reset;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            instr_count <= '0;
        end else if (!stall) begin
            instr_count <= instr_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_instruction_decoder.sv
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run compared every cycle against a behavioural model.
module tb_instruction_decoder;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          sync_reset;
    logic [7:0]    ir;
    logic          alu_zero;
    logic          jmp, jmp_nz, dont_jmp, NOPD8, imm_sel, alu_en, alu_y_sel, stall;
    logic [3:0]    jmp_addr, alu_fn;
    logic [7:0]    reg_en;
    logic [2:0]    src_sel;
    logic [CW-1:0] instr_count;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    // model state: value the DUT registers hold during the current cycle
    int m_z = 0;
    int m_phase = 0;
    int m_count = 0;

    instruction_decoder #(.NOP_CODE(8'hBF), .CNT_W(CW)) dut (
        .clk         (clk),
        .sync_reset  (sync_reset),
        .ir          (ir),
        .alu_zero    (alu_zero),
        .jmp         (jmp),
        .jmp_nz      (jmp_nz),
        .jmp_addr    (jmp_addr),
        .dont_jmp    (dont_jmp),
        .NOPD8       (NOPD8),
        .reg_en      (reg_en),
        .src_sel     (src_sel),
        .imm_sel     (imm_sel),
        .alu_en      (alu_en),
        .alu_y_sel   (alu_y_sel),
        .alu_fn      (alu_fn),
        .stall       (stall),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, then advance the model through the coming edge.
    always @(negedge clk) begin
        if (started) begin
            int v, e_reg, e_src, e_imm, e_alu, e_y, e_fn, e_jmp, e_jnz, e_addr, e_nop, e_stall, e_dj;
            bit rst, is_nop, is_load, is_move, is_alu, is_jmp, is_jnz;
            v   = int'(ir);
            rst = sync_reset;
            is_nop  = !rst && v == 8'hBF;
            is_load = !rst && !is_nop && v < 128;
            is_move = !rst && !is_nop && v >= 128 && v < 192;
            is_alu  = !rst && v >= 192 && v < 224;
            is_jmp  = !rst && v / 16 == 14;
            is_jnz  = !rst && v / 16 == 15;
            e_reg  = is_load ? (1 << ((v / 16) % 8)) : is_move ? (1 << ((v / 8) % 8)) : 0;
            e_src  = is_move ? v % 8 : 0;
            e_imm  = is_load ? 1 : 0;
            e_alu  = is_alu ? 1 : 0;
            e_y    = is_alu ? (v / 16) % 2 : 0;
            e_fn   = is_alu ? v % 16 : 0;
            e_jmp  = is_jmp ? 1 : 0;
            e_jnz  = is_jnz ? 1 : 0;
            e_addr = (is_jmp || is_jnz) ? v % 16 : 0;
            e_nop  = is_nop ? 1 : 0;
            e_stall = (is_nop && m_phase < 2) ? 1 : 0;
            e_dj   = rst ? 0 : m_z;

            check("reg_en", 32'(reg_en), 32'(e_reg));
            check("src_sel", 32'(src_sel), 32'(e_src));
            check("imm_sel", 32'(imm_sel), 32'(e_imm));
            check("alu_en", 32'(alu_en), 32'(e_alu));
            check("alu_y_sel", 32'(alu_y_sel), 32'(e_y));
            check("alu_fn", 32'(alu_fn), 32'(e_fn));
            check("jmp", 32'(jmp), 32'(e_jmp));
            check("jmp_nz", 32'(jmp_nz), 32'(e_jnz));
            check("jmp_addr", 32'(jmp_addr), 32'(e_addr));
            check("NOPD8", 32'(NOPD8), 32'(e_nop));
            check("stall", 32'(stall), 32'(e_stall));
            check("dont_jmp", 32'(dont_jmp), 32'(e_dj));
            check("instr_count", 32'(instr_count), 32'(m_count));
            check("cnt", 32'(dut.u_stall.cnt), 32'(m_phase));

            if (rst) begin
                m_z = 0;
                m_phase = 0;
                m_count = 0;
            end else begin
                if (is_alu) m_z = alu_zero ? 1 : 0;
                if (is_nop && m_phase != 2) m_phase = m_phase + 1;
                else if (m_phase == 2) m_phase = 0;
                if (e_stall == 0) m_count = (m_count + 1) % (1 << CW);
            end
        end
    end

    task automatic drive(input logic rst, input logic [7:0] i, input logic az);
        @(posedge clk);
        #1;
        sync_reset = rst;
        ir = i;
        alu_zero = az;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        sync_reset = 1'b1;
        ir = 8'h5A;
        alu_zero = 1'b0;
        @(posedge clk);
        started = 1'b1;
        @(posedge clk);
        settle();
        check("rst reg_en", 32'(reg_en), 32'h0);
        check("rst imm_sel", 32'(imm_sel), 32'h0);
        check("rst instr_count", 32'(instr_count), 32'h0);
        check("rst dont_jmp", 32'(dont_jmp), 32'h0);

        drive(0, 8'h37, 0); settle();
        check("ld reg_en", 32'(reg_en), 32'h08);
        check("ld imm_sel", 32'(imm_sel), 32'h1);
        drive(0, 8'h9A, 0); settle();
        check("mv reg_en", 32'(reg_en), 32'h08);
        check("mv src_sel", 32'(src_sel), 32'h2);

        drive(0, 8'hC5, 1); settle();
        check("alu alu_fn", 32'(alu_fn), 32'h5);
        drive(0, 8'hF3, 0); settle();
        check("jnz jmp_nz", 32'(jmp_nz), 32'h1);
        check("jnz jmp_addr", 32'(jmp_addr), 32'h3);
        check("jnz dont_jmp z1", 32'(dont_jmp), 32'h1);
        drive(0, 8'hE7, 0); settle();
        check("jmp jmp", 32'(jmp), 32'h1);
        check("jmp jmp_addr", 32'(jmp_addr), 32'h7);
        check("jmp keeps z", 32'(dont_jmp), 32'h1);
        drive(0, 8'hC5, 0);
        drive(0, 8'hF3, 0); settle();
        check("jnz dont_jmp z0", 32'(dont_jmp), 32'h0);

        // NOPD8 from a known count
        drive(1, 8'hBF, 0); settle();
        check("rst stall", 32'(stall), 32'h0);
        check("rst NOPD8", 32'(NOPD8), 32'h0);
        drive(0, 8'hBF, 0); settle();
        check("nop0 stall", 32'(stall), 32'h1);
        check("nop0 reg_en", 32'(reg_en), 32'h0);
        check("nop0 count", 32'(instr_count), 32'h0);
        drive(0, 8'hBF, 0); settle();
        check("nop1 stall", 32'(stall), 32'h1);
        check("nop1 cnt", 32'(dut.u_stall.cnt), 32'h1);
        drive(0, 8'hBF, 0); settle();
        check("nop2 stall", 32'(stall), 32'h0);
        check("nop2 cnt", 32'(dut.u_stall.cnt), 32'h2);
        check("nop2 count", 32'(instr_count), 32'h0);
        drive(0, 8'h10, 0); settle();
        check("nop done cnt", 32'(dut.u_stall.cnt), 32'h0);
        check("nop done count", 32'(instr_count), 32'h1);

        // reset while cnt=1, then a refetched NOPD8 runs all 3 phases
        drive(0, 8'hBF, 0);
        drive(0, 8'hBF, 0); settle();
        check("mid cnt before rst", 32'(dut.u_stall.cnt), 32'h1);
        drive(1, 8'hBF, 0); settle();
        check("mid rst stall", 32'(stall), 32'h0);
        drive(0, 8'hBF, 0); settle();
        check("refetch cnt0", 32'(dut.u_stall.cnt), 32'h0);
        check("refetch stall0", 32'(stall), 32'h1);
        drive(0, 8'hBF, 0); settle();
        check("refetch stall1", 32'(stall), 32'h1);
        drive(0, 8'hBF, 0); settle();
        check("refetch stall2", 32'(stall), 32'h0);
        drive(0, 8'h00, 0); settle();
        check("refetch count", 32'(instr_count), 32'h1);

        // 16 retirements wrap a 4-bit counter back to 0
        drive(1, 8'h01, 0);
        for (int k = 0; k < 16; k++) drive(0, 8'h01, 0);
        settle();
        check("wrap pre", 32'(instr_count), 32'hF);
        drive(0, 8'h01, 0); settle();
        check("wrap zero", 32'(instr_count), 32'h0);

        // randomized traffic; NOPD8 is weighted so multi-cycle stalls occur often
        for (int k = 0; k < 2000; k++) begin
            logic [7:0] r;
            r = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 99) < 30) r = 8'hBF;
            drive(logic'($urandom_range(0, 99) < 3), r, logic'($urandom_range(0, 1)));
        end
        settle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instruction_decoder.md
# instruction_decoder

Instruction decoder for the 8-bit microprocessor core; the consumer end of the program-memory/sequencer interface. It takes the instruction word fetched at `pm_addr` and produces the control set the program sequencer consumes: `jmp`, `jmp_nz`, `jmp_addr`, `dont_jmp` and `NOPD8`. It also drives the datapath register/ALU controls. It owns the zero flag and a stall-phase counter that mirrors the sequencer's NOPD8 counter, so datapath effects and retirement stay aligned with `pc`.

## Interface
- `NOP_CODE`, default 8'hBF: encoding of the 3-cycle NOPD8 instruction.
- `CNT_W`, default 16: width of the retired-instruction counter.
- `clk` input, 1: system clock; all state updates on the rising edge.
- `sync_reset` input, 1: synchronous, active-high reset.
- `ir` input, 8: instruction word from program memory for the current `pc`.
- `alu_zero` input, 1: ALU result of the current instruction equals 0.
- `jmp` output, 1: unconditional jump.
- `jmp_nz` output, 1: conditional jump, taken when the zero flag is clear.
- `jmp_addr` output, 4: jump page; the sequencer forms `{jmp_addr,4'h0}`.
- `dont_jmp` output, 1: registered zero flag.
- `NOPD8` output, 1: the current instruction is `NOP_CODE`.
- `reg_en` output, 8: one-hot destination write enable, codes 0–7.
- `src_sel` output, 3: move source register code.
- `imm_sel` output, 1: destination data comes from `ir[3:0]`.
- `alu_en` output, 1: ALU instruction.
- `alu_y_sel` output, 1: ALU operand select (`ir[4]`).
- `alu_fn` output, 4: ALU function (`ir[3:0]`).
- `stall` output, 1: sequencer is holding `pc` this cycle.
- `instr_count` output, CNT_W: retired instructions since reset.

## Operation
- Decode of `ir`, in priority order:
  - `ir == NOP_CODE`: `NOPD8`=1. All of `reg_en`, `alu_en`, `jmp` and `jmp_nz` are 0.
  - `ir[7]==0`, load immediate: `reg_en[ir[6:4]]`=1, `imm_sel`=1.
  - `ir[7:6]==2'b10`, move: `reg_en[ir[5:3]]`=1, `src_sel`=`ir[2:0]`.
  - `ir[7:5]==3'b110`, ALU: `alu_en`=1, `alu_y_sel`=`ir[4]`, `alu_fn`=`ir[3:0]`.
  - `ir[7:4]==4'hE`: `jmp`=1, `jmp_addr`=`ir[3:0]`.
  - `ir[7:4]==4'hF`: `jmp_nz`=1, `jmp_addr`=`ir[3:0]`.
- Unused fields are driven to 0.
- Zero flag `z`:
  - On a clock edge with `alu_en`=1, `z` <= `alu_zero`.
  - Otherwise `z` holds.
  - `dont_jmp` = `z`.
- Stall counter `cnt` (2 bits), matching the sequencer exactly:
  - If `NOPD8` and `cnt`!=2: `cnt`+1.
  - Else if `cnt`==2: 0.
  - Else hold.
  - `stall` = `NOPD8` && `cnt`<2.
- Retire counter:
  - `instr_count` increments on every edge where `stall`=0 and `sync_reset`=0.
  - It wraps modulo 2^CNT_W.
- While `sync_reset`=1, every combinational output is forced to 0.

## Timing
- All decode outputs are combinational from `ir`, `z` and `cnt` within the same cycle (zero latency), matching the sequencer's combinational `pm_addr` path.
- Reset, at the edge with `sync_reset`=1: `z`=0, `cnt`=0, `instr_count`=0. All outputs read 0 during reset.
- Reset asserted mid-NOPD8 aborts the stall: `cnt` returns to 0, and the NOPD8 restarts its full 3 cycles if it is refetched.
- NOPD8 occupies exactly 3 cycles (`cnt` = 0, 1, 2). `stall`=1 for the first two; `instr_count` increments once, on the third.
- ALU followed directly by `jmp_nz`: the flag written at the ALU edge is visible to the `jmp_nz` in the next cycle.
- A `jmp` or `jmp_nz` retires in one cycle. `z` is unaffected by jumps, moves and loads.
- `alu_en`=1 and `sync_reset`=1 in the same cycle: reset wins, so `z`=0.

## Structure
- Shared package holds:
  - opcode prefix constants (LOAD, MOVE, ALU, JMP=4'hE, JNZ=4'hF);
  - `NOP_CODE`;
  - register codes 0–7;
  - a `STALL_LAST`=2'd2 constant, shared with the program sequencer so the two counters cannot diverge.
- Natural sub-module: `nop_stall_counter`, containing `cnt` and the `stall` output. The program sequencer is expected to reuse it later.

## Test plan
- **Reset:** hold `sync_reset` for 2 cycles with `ir`=8'h5A. Required: all outputs 0, `instr_count`=0, `dont_jmp`=0.
- **Load/move decode:**
  - `ir`=8'h37 → `reg_en`=8'b0000_1000, `imm_sel`=1.
  - `ir`=8'h9A → `reg_en`=8'b0000_1000, `src_sel`=3'd2.
- **Zero flag + branch:**
  - `ir`=8'hC5 with `alu_zero`=1, then `ir`=8'hF3 → `jmp_nz`=1, `jmp_addr`=4'h3, `dont_jmp`=1.
  - Repeat with `alu_zero`=0 → `dont_jmp`=0.
- **NOPD8:** hold `ir`=8'hBF for 3 cycles. Required:
  - `stall`=1,1,0;
  - `cnt`=0,1,2 then 0;
  - `instr_count` increases by exactly 1;
  - `reg_en`=0 throughout.
- **Reset mid-stall:** assert `sync_reset` at `cnt`=1. Required: `cnt`=0, `stall`=0 during reset, and a refetched 8'hBF takes 3 more cycles.
- **Unconditional jump + counter wrap:** `ir`=8'hE7 → `jmp`=1, `jmp_addr`=4'h7, `z` unchanged. With `CNT_W`=4, 16 retirements return `instr_count` to 0.
